// File: rtl/fault_monitor_pkg.sv
// Shared definitions for the hull-fault monitor: channel state encoding,
// register addresses and CTRL register bit positions.
package fault_monitor_pkg;

    // Per-channel supervisor state. RUN is the only state that lets a motor run.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRIP = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_e;

    // Avalon word addresses.
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STICKY = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // CTRL register layout.
    localparam int CTRL_AUTO_RETRY  = 0;
    localparam int CTRL_FORCE_OFF   = 1;
    localparam int CTRL_NOT_RUN_LSB = 8;

endpackage

// File: rtl/fault_monitor_ctrl_if.sv
// Avalon-MM slave bus of the fault monitor, plus its level interrupt.
//
// Handshake: there is no wait-state or valid/ready pair. A write takes effect
// on the rising edge where write is high. readdata is registered from the
// address mux every cycle, regardless of read, so it shows the register
// selected by address one cycle earlier.
interface fault_monitor_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/fault_chan.sv
// One fault channel: 2-FF synchroniser, debounce filter and the
// RUN/TRIP/HOLD supervisor that decides whether the motor may run.
module fault_chan
    import fault_monitor_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_raw,      // asynchronous fault line, 1 = fault
    input  logic        retry_ok,    // HOLD may return to RUN once the hold time has expired
    output logic        deb_o,       // debounced fault level
    output logic        deb_rise_o,  // one-cycle pulse on a debounced rising edge
    output logic        run_o,       // registered: state is RUN
    output chan_state_e state_o      // current supervisor state
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              deb_q, deb_d;
    logic              deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

    chan_state_e       state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              run_q;

    // Synchroniser shift and debounce: a new level is accepted only after it
    // has differed from deb for DEB_CYCLES consecutive cycles.
    always_comb begin
        sync1_d    = in_raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Synchroniser and debounce registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // Trip/hold/retry supervisor; run_q tracks the next state so it is a
    // registered copy of (state == RUN).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
            run_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (deb_q) begin
                        state_q <= ST_TRIP;
                        run_q   <= 1'b0;
                    end
                end
                ST_TRIP: begin
                    if (!deb_q) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (deb_q) begin
                        // Fault returned: abandon the hold countdown.
                        state_q <= ST_TRIP;
                    end else if (hold_cnt_q != '0) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end else if (retry_ok) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fail safe with the motor off.
                    state_q <= ST_TRIP;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign deb_o      = deb_q;
    assign deb_rise_o = deb_q & ~deb_prev_q;
    assign run_o      = run_q;
    assign state_o    = state_q;

endmodule

// File: rtl/fault_monitor_ctrl.sv
// Hull-fault monitor for four wheel drivers and the dribbler. Per-channel
// filtering and motor supervision live in fault_chan; this level holds the
// CPU-visible registers, sticky fault bits, read mux and interrupt.
module fault_monitor_ctrl
    import fault_monitor_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     in_port,
    fault_monitor_ctrl_if.slave bus,
    output logic [N_CH-1:0]     motor_en
);

    logic [N_CH-1:0] deb;
    logic [N_CH-1:0] deb_rise;
    logic [N_CH-1:0] run;
    logic [N_CH-1:0] not_run;
    logic [N_CH-1:0] retry_ok;
    chan_state_e     chan_state [N_CH];

    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] sticky_q, sticky_d;
    logic [N_CH-1:0] sticky_clr;
    logic            auto_retry_q, auto_retry_d;
    logic            force_off_q, force_off_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            irq_q, irq_d;

    // The bus is always-valid, so read is not needed; upper write bits have no home.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.read, bus.writedata[31:N_CH]};

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        assign retry_ok[i] = auto_retry_q | ~sticky_q[i];

        fault_chan #(
            .DEB_CYCLES  (DEB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .in_raw     (in_port[i]),
            .retry_ok   (retry_ok[i]),
            .deb_o      (deb[i]),
            .deb_rise_o (deb_rise[i]),
            .run_o      (run[i]),
            .state_o    (chan_state[i])
        );

        assign not_run[i] = (chan_state[i] != ST_RUN);
    end

    // Register writes; sticky set from a debounced rising edge beats a same-cycle clear.
    always_comb begin
        mask_d       = mask_q;
        auto_retry_d = auto_retry_q;
        force_off_d  = force_off_q;
        sticky_clr   = '0;
        if (bus.write) begin
            case (bus.address)
                ADDR_MASK:   mask_d = bus.writedata[N_CH-1:0];
                ADDR_STICKY: sticky_clr = bus.writedata[N_CH-1:0];
                ADDR_CTRL: begin
                    auto_retry_d = bus.writedata[CTRL_AUTO_RETRY];
                    force_off_d  = bus.writedata[CTRL_FORCE_OFF];
                end
                default: ;
            endcase
        end
        sticky_d = (sticky_q & ~sticky_clr) | deb_rise;
        irq_d    = |(sticky_q & mask_q);
    end

    // Read mux, captured every cycle so readdata lags address by one cycle.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_STATUS: readdata_d[N_CH-1:0] = deb;
            ADDR_MASK:   readdata_d[N_CH-1:0] = mask_q;
            ADDR_STICKY: readdata_d[N_CH-1:0] = sticky_q;
            ADDR_CTRL: begin
                readdata_d[CTRL_AUTO_RETRY]            = auto_retry_q;
                readdata_d[CTRL_FORCE_OFF]             = force_off_q;
                readdata_d[CTRL_NOT_RUN_LSB +: N_CH]   = not_run;
            end
            default: ;
        endcase
    end

    // Register file, sticky bits, read data and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= '0;
            sticky_q     <= '0;
            auto_retry_q <= 1'b0;
            force_off_q  <= 1'b0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            sticky_q     <= sticky_d;
            auto_retry_q <= auto_retry_d;
            force_off_q  <= force_off_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
    assign motor_en     = run & {N_CH{~force_off_q}};

endmodule
